// File: rtl/ov7670_pkg.sv
// Shared types and helpers for the OV7670 capture path and the image-ROM readers.
// Holds the capture FSM states, default frame geometry and RGB565 -> RGB444 packing.
package ov7670_pkg;

  typedef enum logic [1:0] {
    WAIT_VSYNC = 2'd0,
    VBLANK     = 2'd1,
    LINE_GAP   = 2'd2,
    ACTIVE     = 2'd3
  } state_t;

  localparam int H_ACTIVE_DEFAULT = 320;
  localparam int V_ACTIVE_DEFAULT = 240;
  localparam int FRAME_PIXELS     = H_ACTIVE_DEFAULT * V_ACTIVE_DEFAULT;

  // Keeps the top four bits of each colour component.
  function automatic logic [11:0] rgb565_to_rgb444(input logic [15:0] p);
    return {p[15:12], p[10:7], p[4:1]};
  endfunction

endpackage

// File: rtl/ov7670_byte_pairer.sv
// Pairs camera bytes into RGB565 pixels: holds byte0, flags the byte1 edge and
// presents the packed 12-bit pixel combinationally alongside it.
module ov7670_byte_pairer
  import ov7670_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_byte_en,
  input  logic        i_first,
  input  logic [7:0]  i_data,
  output logic        o_phase,
  output logic        o_pixel_valid,
  output logic [11:0] o_pixel
);

  logic       r_phase;
  logic [7:0] r_byte0;
  logic       w_second;

  // A line-start byte is always byte0, whatever the previous line left behind.
  assign w_second = r_phase & ~i_first;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase <= 1'b0;
      r_byte0 <= 8'd0;
    end else if (i_byte_en) begin
      r_phase <= ~w_second;
      if (!w_second) r_byte0 <= i_data;
    end
  end

  assign o_phase       = r_phase;
  assign o_pixel_valid = i_byte_en & w_second;
  assign o_pixel       = rgb565_to_rgb444({r_byte0, i_data});

endmodule

// File: rtl/ov7670_frame_writer.sv
// Camera-side writer for the RGB444 frame buffer: capture FSM, x/y counters,
// running row-major write address and per-frame done/error reporting.
module ov7670_frame_writer
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int V_ACTIVE = V_ACTIVE_DEFAULT,
  parameter int ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        data,
  output logic              we,
  output logic [ADDR_W-1:0] wAddr,
  output logic [11:0]       wData,
  output logic              frame_done,
  output logic              frame_err,
  output state_t            dbg_state
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0]     X_MAX = XW'(H_ACTIVE);
  localparam logic [YW-1:0]     Y_MAX = YW'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] A_ROW = ADDR_W'(H_ACTIVE);

  state_t            r_state, w_state_next;
  logic [XW-1:0]     r_x;
  logic              r_x_over;
  logic [YW-1:0]     r_y;
  logic              r_err;
  logic [ADDR_W-1:0] r_addr, r_line_base;
  logic              r_we, r_frame_done, r_frame_err;
  logic [ADDR_W-1:0] r_wAddr;
  logic [11:0]       r_wData;

  logic        w_frame_start, w_line_start, w_byte_en, w_line_end, w_frame_end;
  logic        w_err_final, w_phase, w_pix_valid, w_write, w_line_bad;
  logic [11:0] w_pixel;

  ov7670_byte_pairer u_pairer (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_byte_en     (w_byte_en),
    .i_first       (w_line_start),
    .i_data        (data),
    .o_phase       (w_phase),
    .o_pixel_valid (w_pix_valid),
    .o_pixel       (w_pixel)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= WAIT_VSYNC;
    else          r_state <= w_state_next;
  end

  // vsync is checked before href everywhere, so a byte coinciding with frame end is dropped.
  always_comb begin
    w_state_next  = r_state;
    w_frame_start = 1'b0;
    w_line_start  = 1'b0;
    w_byte_en     = 1'b0;
    w_line_end    = 1'b0;
    w_frame_end   = 1'b0;
    w_err_final   = r_err | (r_y != Y_MAX);
    case (r_state)
      WAIT_VSYNC: if (vsync) w_state_next = VBLANK;
      VBLANK: begin
        if (!vsync) begin
          w_frame_start = 1'b1;
          w_state_next  = LINE_GAP;
        end
      end
      LINE_GAP: begin
        if (vsync) begin
          w_frame_end  = 1'b1;
          w_state_next = VBLANK;
        end else if (href) begin
          w_byte_en    = 1'b1;
          w_line_start = 1'b1;
          w_state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (vsync) begin
          w_frame_end  = 1'b1;
          w_err_final  = 1'b1;
          w_state_next = VBLANK;
        end else if (href) begin
          w_byte_en = 1'b1;
        end else begin
          w_line_end   = 1'b1;
          w_state_next = LINE_GAP;
        end
      end
      default: w_state_next = WAIT_VSYNC;
    endcase
  end

  assign w_write    = w_pix_valid & (r_x < X_MAX) & (r_y < Y_MAX);
  assign w_line_bad = w_phase | (r_x != X_MAX) | r_x_over;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x          <= '0;
      r_x_over     <= 1'b0;
      r_y          <= '0;
      r_err        <= 1'b0;
      r_addr       <= '0;
      r_line_base  <= '0;
      r_we         <= 1'b0;
      r_wAddr      <= '0;
      r_wData      <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_we         <= w_write;
      r_frame_done <= w_frame_end & ~w_err_final;
      r_frame_err  <= w_frame_end & w_err_final;
      if (w_write) begin
        r_wAddr <= r_addr;
        r_wData <= w_pixel;
        r_addr  <= r_addr + ADDR_W'(1);
      end
      if (w_frame_start) begin
        r_y         <= '0;
        r_err       <= 1'b0;
        r_addr      <= '0;
        r_line_base <= '0;
      end
      if (w_line_start) begin
        r_x      <= '0;
        r_x_over <= 1'b0;
      end
      // x stops at H_ACTIVE; surplus pixels only mark the line as overlong.
      if (w_pix_valid) begin
        if (r_x == X_MAX) r_x_over <= 1'b1;
        else              r_x      <= r_x + XW'(1);
      end
      if (w_line_end) begin
        if (w_line_bad) r_err <= 1'b1;
        if (r_y < Y_MAX) begin
          r_y         <= r_y + YW'(1);
          r_line_base <= r_line_base + A_ROW;
          r_addr      <= r_line_base + A_ROW;
        end
      end
    end
  end

  assign we         = r_we;
  assign wAddr      = r_wAddr;
  assign wData      = r_wData;
  assign frame_done = r_frame_done;
  assign frame_err  = r_frame_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_ov7670_frame_writer.sv
// Bench for ov7670_frame_writer on a reduced 32x12 frame: random pixel streams
// scored against a row-major reference model, plus table and corner sequences.
module tb_ov7670_frame_writer;
  import ov7670_pkg::*;

  localparam int H  = 32;
  localparam int V  = 12;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          reset_n, vsync, href;
  logic [7:0]    data;
  logic          we, frame_done, frame_err;
  logic [AW-1:0] wAddr;
  logic [11:0]   wData;
  state_t        dbg_state;

  ov7670_frame_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .vsync(vsync), .href(href), .data(data),
    .we(we), .wAddr(wAddr), .wData(wData), .frame_done(frame_done),
    .frame_err(frame_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int n_checks = 0, n_errors = 0;
  logic [AW+11:0] exp_q[$];
  logic [AW+11:0] mon_e;
  int exp_done = 0, exp_err = 0, act_done = 0, act_err = 0;
  int wr_frame = 0, wr_total = 0;
  logic [AW-1:0] last_addr = '0;
  int m_line = 0;
  bit m_err = 1'b0;
  logic [15:0] line_pix [0:2*H];
  int probe_line = -1, probe_x = -1;
  logic [AW-1:0] probe_addr = '0;
  logic [11:0] probe_data = '0;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [11:0] exp;
  } pack_vec_t;
  pack_vec_t tbl [0:7];

  function automatic void chk(input bit ok, input string name,
                              input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [11:0] ref_pack(input logic [15:0] p);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    r5 = p[15:11];
    g6 = p[10:5];
    b5 = p[4:0];
    return {r5[4:1], g6[5:2], b5[4:1]};
  endfunction

  function automatic void model_pixel(input int line, input int x, input logic [15:0] p);
    logic [AW-1:0] a;
    if (line < V && x < H) begin
      a = AW'(line * H + x);
      exp_q.push_back({a, ref_pack(p)});
    end
  endfunction

  function automatic void model_line_end(input int nbytes);
    if ((nbytes % 2) != 0 || (nbytes / 2) != H) m_err = 1'b1;
    m_line++;
  endfunction

  function automatic void model_frame_end(input bit trunc);
    int lines;
    lines = (m_line < V) ? m_line : V;
    if (m_err || trunc || lines != V) exp_err++;
    else                              exp_done++;
  endfunction

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      if (we) begin
        wr_frame++;
        wr_total++;
        last_addr = wAddr;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_write", 32'(wAddr), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk({wAddr, wData} == mon_e, "write_addr_data", 32'({wAddr, wData}), 32'(mon_e));
        end
      end
      if (frame_done) act_done++;
      if (frame_err)  act_err++;
      if (frame_done || frame_err)
        chk(!(frame_done && frame_err), "done_err_exclusive",
            32'({frame_done, frame_err}), 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      href = 1'b0;
      data = 8'($urandom);
    end
  endtask

  task automatic vsync_high();
    @(negedge clk);
    vsync = 1'b1;
    href  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic vsync_low();
    @(negedge clk);
    vsync    = 1'b0;
    m_line   = 0;
    m_err    = 1'b0;
    wr_frame = 0;
    @(negedge clk);
  endtask

  task automatic fill_line();
    for (int i = 0; i <= 2 * H; i++) line_pix[i] = 16'($urandom);
  endtask

  task automatic drive_byte(input int k);
    logic [15:0] p;
    @(negedge clk);
    vsync = 1'b0;
    href  = 1'b1;
    p     = line_pix[k/2];
    data  = (k % 2 == 0) ? p[15:8] : p[7:0];
    if (k % 2 == 1) begin
      model_pixel(m_line, k / 2, p);
      if (m_line == probe_line && k / 2 == probe_x) begin
        @(posedge clk); #1;
        chk(we == 1'b1, "probe_we", 32'(we), 32'd1);
        chk(wAddr == probe_addr, "probe_addr", 32'(wAddr), 32'(probe_addr));
        chk(wData == probe_data, "probe_data", 32'(wData), 32'(probe_data));
      end
    end else if (m_line == probe_line && k / 2 == probe_x + 1) begin
      @(posedge clk); #1;
      chk(we == 1'b0, "probe_we_one_cycle", 32'(we), 32'd0);
    end
  endtask

  task automatic send_line(input int nbytes, input bit trunc);
    for (int k = 0; k < nbytes; k++) drive_byte(k);
    if (trunc) begin
      @(negedge clk);
      vsync = 1'b1;
      href  = 1'b1;
      data  = 8'($urandom);
      model_frame_end(1'b1);
      @(negedge clk);
      href = 1'b0;
      @(negedge clk);
    end else begin
      model_line_end(nbytes);
      idle(3);
    end
  endtask

  task automatic end_frame(input string name);
    model_frame_end(1'b0);
    vsync_high();
    chk(act_done == exp_done, {name, "_done_count"}, 32'(act_done), 32'(exp_done));
    chk(act_err == exp_err, {name, "_err_count"}, 32'(act_err), 32'(exp_err));
  endtask

  task automatic clean_frame(input string name);
    vsync_low();
    for (int l = 0; l < V; l++) begin
      fill_line();
      send_line(2 * H, 1'b0);
    end
    end_frame(name);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int w0;
    tbl[0] = '{8'hF8, 8'h1F, 12'hF0F};
    tbl[1] = '{8'h07, 8'hE0, 12'h0F0};
    tbl[2] = '{8'h00, 8'h1F, 12'h00F};
    tbl[3] = '{8'hFF, 8'hFF, 12'hFFF};
    tbl[4] = '{8'h00, 8'h00, 12'h000};
    tbl[5] = '{8'h12, 8'h34, 12'h14A};
    tbl[6] = '{8'hA5, 8'h5A, 12'hAAD};
    tbl[7] = '{8'h7B, 8'hEF, 12'h777};

    reset_n = 1'b0; vsync = 1'b0; href = 1'b0; data = 8'd0;
    repeat (3) @(negedge clk);
    chk(we == 1'b0, "reset_we", 32'(we), 32'd0);
    chk(wAddr == '0, "reset_wAddr", 32'(wAddr), 32'd0);
    chk(wData == '0, "reset_wData", 32'(wData), 32'd0);
    chk(frame_done == 1'b0, "reset_frame_done", 32'(frame_done), 32'd0);
    chk(frame_err == 1'b0, "reset_frame_err", 32'(frame_err), 32'd0);
    chk(dbg_state == WAIT_VSYNC, "reset_state", 32'(dbg_state), 32'(WAIT_VSYNC));
    reset_n = 1'b1;

    // Bytes before any vsync must be ignored.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      href = 1'b1;
      data = 8'($urandom);
    end
    idle(2);
    chk(wr_total == 0, "no_write_before_vsync", 32'(wr_total), 32'd0);
    vsync_high();

    // Clean frame with probes at (0,0) and (5,2).
    vsync_low();
    for (int l = 0; l < V; l++) begin
      fill_line();
      if (l == 0) begin
        line_pix[0] = 16'hF81F;
        probe_line = 0; probe_x = 0; probe_addr = '0; probe_data = 12'hF0F;
      end else if (l == 2) begin
        line_pix[5] = 16'h07E0;
        probe_line = 2; probe_x = 5; probe_addr = AW'(2 * H + 5); probe_data = 12'h0F0;
      end
      send_line(2 * H, 1'b0);
    end
    probe_line = -1;
    end_frame("clean");
    chk(wr_frame == H * V, "clean_write_count", 32'(wr_frame), 32'(H * V));
    chk(last_addr == AW'(H * V - 1), "clean_last_addr", 32'(last_addr), 32'(H * V - 1));

    // Packing table: one short line, each pair checked one cycle after byte1.
    vsync_low();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      href = 1'b1;
      data = tbl[i].b0;
      @(negedge clk);
      data = tbl[i].b1;
      model_pixel(0, i, {tbl[i].b0, tbl[i].b1});
      @(posedge clk); #1;
      chk(we == 1'b1, "table_we", 32'(we), 32'd1);
      chk(wData == tbl[i].exp, "table_wData", 32'(wData), 32'(tbl[i].exp));
      chk(wAddr == AW'(i), "table_wAddr", 32'(wAddr), 32'(i));
    end
    model_line_end(16);
    idle(3);
    end_frame("table_frame");

    // Long first line: surplus pixels dropped, next row still starts at H.
    vsync_low();
    for (int l = 0; l < V; l++) begin
      fill_line();
      send_line((l == 0) ? 2 * H + 20 : 2 * H, 1'b0);
    end
    end_frame("long_line");
    chk(wr_frame == H * V, "long_line_write_count", 32'(wr_frame), 32'(H * V));

    // Short frame, then a clean frame restarting at address 0.
    vsync_low();
    for (int l = 0; l < 5; l++) begin
      fill_line();
      send_line(2 * H, 1'b0);
    end
    end_frame("short_frame");
    clean_frame("after_short");

    // Odd-byte line and a short line (row skip), then a clean frame.
    vsync_low();
    for (int l = 0; l < V; l++) begin
      fill_line();
      send_line((l == 3) ? 2 * H + 1 : (l == 6) ? 2 * H - 10 : 2 * H, 1'b0);
    end
    end_frame("odd_line");
    clean_frame("after_odd");

    // Extra lines beyond V are dropped and do not flag an error.
    vsync_low();
    for (int l = 0; l < V + 2; l++) begin
      fill_line();
      send_line(2 * H, 1'b0);
    end
    end_frame("extra_lines");
    chk(wr_frame == H * V, "extra_lines_write_count", 32'(wr_frame), 32'(H * V));

    // vsync rises mid-line together with href: truncated frame, byte ignored.
    vsync_low();
    for (int l = 0; l < V - 1; l++) begin
      fill_line();
      send_line(2 * H, 1'b0);
    end
    fill_line();
    send_line(9, 1'b1);
    chk(act_err == exp_err, "truncated_err_count", 32'(act_err), 32'(exp_err));
    chk(act_done == exp_done, "truncated_done_count", 32'(act_done), 32'(exp_done));

    // Asynchronous reset mid-line on y=5.
    vsync_low();
    for (int l = 0; l < 5; l++) begin
      fill_line();
      send_line(2 * H, 1'b0);
    end
    fill_line();
    for (int k = 0; k < 11; k++) drive_byte(k);
    #2 reset_n = 1'b0;
    #1;
    chk(we == 1'b0, "async_reset_we", 32'(we), 32'd0);
    chk(wAddr == '0, "async_reset_wAddr", 32'(wAddr), 32'd0);
    chk(wData == '0, "async_reset_wData", 32'(wData), 32'd0);
    chk(dbg_state == WAIT_VSYNC, "async_reset_state", 32'(dbg_state), 32'(WAIT_VSYNC));
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    w0 = wr_total;
    for (int i = 0; i < 3 * 2 * H; i++) begin
      @(negedge clk);
      href = ((i % (2 * H + 3)) < 2 * H);
      data = 8'($urandom);
    end
    idle(3);
    chk(wr_total == w0, "no_write_after_reset", 32'(wr_total - w0), 32'd0);
    vsync_high();
    chk(act_done == exp_done, "reset_resync_done", 32'(act_done), 32'(exp_done));
    chk(act_err == exp_err, "reset_resync_err", 32'(act_err), 32'(exp_err));
    vsync_low();
    fill_line();
    probe_line = 0; probe_x = 0; probe_addr = '0; probe_data = ref_pack(line_pix[0]);
    send_line(2 * H, 1'b0);
    probe_line = -1;
    for (int l = 1; l < V; l++) begin
      fill_line();
      send_line(2 * H, 1'b0);
    end
    end_frame("after_reset");

    idle(4);
    chk(exp_q.size() == 0, "expected_writes_drained", 32'(exp_q.size()), 32'd0);
    chk(act_done == 5, "total_frame_done", 32'(act_done), 32'd5);
    chk(act_err == 5, "total_frame_err", 32'(act_err), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
